// File: rtl/rr_mux_arbiter_pkg.sv
// ============================================================================
// rr_arb_pkg : shared types and index helpers for the round-robin mux arbiter
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package rr_arb_pkg;

   localparam int c_DEF_N_REQ = 4;
   localparam int c_DEF_W     = 8;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Explicit compare instead of a power-of-2 wrap so any N works.
   function automatic int rr_next(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

   function automatic int rot_add(input int a, input int b, input int n);
      return (a + b >= n) ? a + b - n : a + b;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_mux_arbiter_if.sv
// ============================================================================
// rr_mux_arbiter_if : requester-side and downstream valid/ready bundle
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rr_mux_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 8
);
   localparam int IW = $clog2(N_REQ);

   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ*W-1:0] req_data;
   logic [N_REQ-1:0]   req_ready;
   logic               out_valid;
   logic [W-1:0]       out_data;
   logic [IW-1:0]      out_src;
   logic               out_ready;

   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_src
   );

   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_src
   );

endinterface

`default_nettype wire

// File: rtl/rr_mux_arbiter_picker.sv
// ============================================================================
// rr_priority_picker : rotate / find-first / un-rotate round-robin pick
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
   import rr_arb_pkg::*;
#(
   parameter int N_REQ = c_DEF_N_REQ,
   parameter int IW    = idx_w(c_DEF_N_REQ)
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IW-1:0]    i_ptr,
   output logic [IW-1:0]    o_pick,
   output logic             o_any
);

   logic [N_REQ-1:0] w_rot;
   int               w_first;

   // w_rot[0] is the requester currently holding top priority.
   always_comb begin
      w_rot = '0;
      for (int j = 0; j < N_REQ; j++) begin
         w_rot[j] = i_req[rot_add(j, int'(i_ptr), N_REQ)];
      end
   end

   always_comb begin
      w_first = 0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_first = j;
         end
      end
   end

   assign o_pick = IW'(rot_add(w_first, int'(i_ptr), N_REQ));
   assign o_any  = |i_req;

endmodule

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// rr_mux_arbiter : round-robin arbiter with one-entry registered output
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_mux_arbiter
   import rr_arb_pkg::*;
#(
   parameter int N_REQ = c_DEF_N_REQ,
   parameter int W     = c_DEF_W
) (
   input  logic             clk,
   input  logic             rst,
   rr_mux_arbiter_if.slave  bus
);

   localparam int IW = idx_w(N_REQ);

   out_state_e       r_state;
   logic [W-1:0]     r_data;
   logic [IW-1:0]    r_src;
   logic [IW-1:0]    r_ptr;

   logic [IW-1:0]    w_pick;
   logic             w_any;
   logic             w_load;
   logic             w_xfer;
   logic [N_REQ-1:0] w_ready;
   logic [W-1:0]     w_sel_data;

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_picker (
      .i_req  (bus.req_valid),
      .i_ptr  (r_ptr),
      .o_pick (w_pick),
      .o_any  (w_any)
   );

   assign w_load     = (r_state == ST_EMPTY) || bus.out_ready;
   // Gated by rst so no requester sees an accept while the block is held in reset.
   assign w_xfer     = w_load && w_any && !rst;
   assign w_sel_data = bus.req_data[int'(w_pick)*W +: W];

   always_comb begin
      w_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_ready[i] = w_xfer && (w_pick == IW'(i));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_EMPTY;
         r_data  <= '0;
         r_src   <= '0;
         r_ptr   <= '0;
      end else if (w_xfer) begin
         r_state <= ST_FULL;
         r_data  <= w_sel_data;
         r_src   <= w_pick;
         r_ptr   <= IW'(rr_next(int'(w_pick), N_REQ));
      end else if (w_load) begin
         r_state <= ST_EMPTY;
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.out_valid = (r_state == ST_FULL);
   assign bus.out_data  = r_data;
   assign bus.out_src   = r_src;

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// ============================================================================
// tb_rr_mux_arbiter : directed scenarios on N_REQ=4 plus random run on N_REQ=3
// Revision          : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_mux_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter_if #(.N_REQ(4), .W(8)) if4 ();
   rr_mux_arbiter_if #(.N_REQ(3), .W(8)) if3 ();

   rr_mux_arbiter #(.N_REQ(4), .W(8)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   rr_mux_arbiter #(.N_REQ(3), .W(8)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic set_data4();
      for (int i = 0; i < 4; i++) begin
         if4.req_data[i*8 +: 8] = 8'(8'hA0 + i);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      set_data4();
      if4.req_valid = 4'hF;
      if4.out_ready = 1'b1;
      if3.req_valid = '0;
      if3.req_data  = '0;
      if3.out_ready = 1'b1;
      repeat (2) tick();
      n_tests++;
      if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", if4.out_valid); end
      n_tests++;
      if (if4.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", if4.out_data); end
      n_tests++;
      if (if4.out_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", if4.out_src); end
      n_tests++;
      if (if4.req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_held: got %b expected 0000", if4.req_ready); end
      rst = 1'b0;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ready: got %b expected 0001", if4.req_ready); end
      tick();
      tick();
      n_tests++;
      if (if4.out_valid !== 1'b1 || if4.out_src !== 2'd1) begin
         n_fail++; $display("FAIL reset_prerun: got v=%b src=%0d expected v=1 src=1", if4.out_valid, if4.out_src);
      end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (if4.out_valid !== 1'b0 || if4.out_data !== 8'h00 || if4.out_src !== 2'd0) begin
         n_fail++; $display("FAIL reset_async: got v=%b d=%h src=%0d expected v=0 d=00 src=0",
                            if4.out_valid, if4.out_data, if4.out_src);
      end
      tick();
      rst = 1'b0;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b0001) begin n_fail++; $display("FAIL reset_ptr_cleared: got %b expected 0001", if4.req_ready); end
      tick();
      n_tests++;
      if (if4.out_valid !== 1'b1 || if4.out_src !== 2'd0 || if4.out_data !== 8'hA0) begin
         n_fail++; $display("FAIL reset_first_grant: got v=%b src=%0d d=%h expected v=1 src=0 d=a0",
                            if4.out_valid, if4.out_src, if4.out_data);
      end
   endtask

   task automatic test_contention();
      logic [3:0] exp_rdy;
      do_reset();
      if4.req_valid = 4'hF;
      if4.out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         #1;
         exp_rdy = 4'(1 << (k % 4));
         n_tests++;
         if (if4.req_ready !== exp_rdy) begin
            n_fail++; $display("FAIL contention_ready[%0d]: got %b expected %b", k, if4.req_ready, exp_rdy);
         end
         tick();
         n_tests++;
         if (if4.out_valid !== 1'b1 || if4.out_src !== 2'(k % 4) || if4.out_data !== 8'(8'hA0 + (k % 4))) begin
            n_fail++; $display("FAIL contention_out[%0d]: got v=%b src=%0d d=%h expected v=1 src=%0d d=%h",
                               k, if4.out_valid, if4.out_src, if4.out_data, k % 4, 8'(8'hA0 + (k % 4)));
         end
      end
   endtask

   task automatic test_sparse();
      do_reset();
      if4.out_ready = 1'b1;
      if4.req_valid = 4'b1000;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_ready3: got %b expected 1000", if4.req_ready); end
      tick();
      n_tests++;
      if (if4.out_src !== 2'd3 || if4.out_data !== 8'hA3) begin
         n_fail++; $display("FAIL sparse_out3: got src=%0d d=%h expected src=3 d=a3", if4.out_src, if4.out_data);
      end
      if4.req_valid = 4'b0010;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b0010) begin n_fail++; $display("FAIL sparse_ready1: got %b expected 0010", if4.req_ready); end
      tick();
      n_tests++;
      if (if4.out_src !== 2'd1 || if4.out_data !== 8'hA1) begin
         n_fail++; $display("FAIL sparse_out1: got src=%0d d=%h expected src=1 d=a1", if4.out_src, if4.out_data);
      end
      if4.req_valid = 4'hF;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b0100) begin n_fail++; $display("FAIL sparse_next: got %b expected 0100", if4.req_ready); end
      tick();
      n_tests++;
      if (if4.out_src !== 2'd2) begin n_fail++; $display("FAIL sparse_out2: got src=%0d expected 2", if4.out_src); end
   endtask

   task automatic test_backpressure();
      do_reset();
      if4.req_data[2*8 +: 8] = 8'h55;
      if4.req_valid = 4'b0100;
      if4.out_ready = 1'b1;
      tick();
      if4.out_ready = 1'b0;
      if4.req_valid = 4'hF;
      for (int k = 0; k < 3; k++) begin
         #1;
         n_tests++;
         if (if4.req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0000", k, if4.req_ready);
         end
         n_tests++;
         if (if4.out_valid !== 1'b1 || if4.out_data !== 8'h55 || if4.out_src !== 2'd2) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got v=%b d=%h src=%0d expected v=1 d=55 src=2",
                               k, if4.out_valid, if4.out_data, if4.out_src);
         end
         tick();
      end
      if4.out_ready = 1'b1;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1000", if4.req_ready); end
      tick();
      n_tests++;
      if (if4.out_valid !== 1'b1 || if4.out_src !== 2'd3 || if4.out_data !== 8'hA3) begin
         n_fail++; $display("FAIL bp_refill: got v=%b src=%0d d=%h expected v=1 src=3 d=a3",
                            if4.out_valid, if4.out_src, if4.out_data);
      end
      set_data4();
   endtask

   task automatic test_idle_gap();
      do_reset();
      if4.out_ready = 1'b1;
      if4.req_valid = 4'b0010;
      tick();
      if4.req_valid = 4'b0000;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b0000) begin n_fail++; $display("FAIL idle_ready: got %b expected 0000", if4.req_ready); end
      tick();
      n_tests++;
      if (if4.out_valid !== 1'b0 || if4.out_src !== 2'd1 || if4.out_data !== 8'hA1) begin
         n_fail++; $display("FAIL idle_drain: got v=%b src=%0d d=%h expected v=0 src=1 d=a1",
                            if4.out_valid, if4.out_src, if4.out_data);
      end
      tick();
      n_tests++;
      if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_stay_empty: got %b expected 0", if4.out_valid); end
      if4.req_valid = 4'b0101;
      #1;
      n_tests++;
      if (if4.req_ready !== 4'b0100) begin n_fail++; $display("FAIL idle_ptr_kept: got %b expected 0100", if4.req_ready); end
      tick();
      n_tests++;
      if (if4.out_src !== 2'd2 || if4.out_data !== 8'hA2) begin
         n_fail++; $display("FAIL idle_winner: got src=%0d d=%h expected src=2 d=a2", if4.out_src, if4.out_data);
      end
      if4.req_valid = 4'b0000;
   endtask

   task automatic test_random();
      logic       pend [3];
      logic [5:0] seq [3];
      logic [5:0] exp_seq [3];
      int         wait_cnt [3];
      logic       m_valid;
      logic [7:0] m_data;
      int         m_src;
      int         m_ptr;
      int         pick;
      int         idx;
      int         max_wait;
      int         src;
      logic       load;
      logic [2:0] exp_rdy;
      logic [7:0] lane;

      for (int i = 0; i < 3; i++) begin
         pend[i] = 1'b0; seq[i] = '0; exp_seq[i] = '0; wait_cnt[i] = 0;
      end
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
      if3.req_valid = '0;
      if3.out_ready = 1'b0;
      do_reset();

      for (int c = 0; c < 300; c++) begin
         n_tests++;
         if (if3.out_valid !== m_valid) begin
            n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, if3.out_valid, m_valid);
         end
         if (m_valid) begin
            n_tests++;
            if (if3.out_data !== m_data || if3.out_src !== 2'(m_src)) begin
               n_fail++; $display("FAIL rand_out[%0d]: got d=%h src=%0d expected d=%h src=%0d",
                                  c, if3.out_data, if3.out_src, m_data, m_src);
            end
         end

         for (int i = 0; i < 3; i++) begin
            if (!pend[i] && $urandom_range(0, 1) == 1) begin
               pend[i] = 1'b1;
               if3.req_data[i*8 +: 8] = {2'(i), seq[i]};
               seq[i] = seq[i] + 6'd1;
               wait_cnt[i] = 0;
            end
            if3.req_valid[i] = pend[i];
         end
         if3.out_ready = ($urandom_range(0, 3) != 0);
         #1;

         load = !m_valid || if3.out_ready;
         pick = -1;
         for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (pick < 0 && pend[idx]) pick = idx;
         end
         exp_rdy = (load && pick >= 0) ? 3'(1 << pick) : 3'b000;
         n_tests++;
         if (if3.req_ready !== exp_rdy) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, if3.req_ready, exp_rdy);
         end

         if (if3.out_valid === 1'b1 && if3.out_ready) begin
            src = int'(if3.out_data[7:6]);
            n_tests++;
            if (src > 2 || if3.out_src !== 2'(src)) begin
               n_fail++; $display("FAIL rand_tag[%0d]: got src=%0d tag=%0d expected equal", c, if3.out_src, src);
            end else begin
               n_tests++;
               if (if3.out_data[5:0] !== exp_seq[src]) begin
                  n_fail++; $display("FAIL rand_order[%0d]: src %0d got seq %0d expected %0d",
                                     c, src, if3.out_data[5:0], exp_seq[src]);
               end
               exp_seq[src] = if3.out_data[5:0] + 6'd1;
            end
         end

         if (if3.req_ready !== 3'b000) begin
            max_wait = 0;
            for (int i = 0; i < 3; i++) begin
               if (pend[i] && !if3.req_ready[i]) begin
                  wait_cnt[i]++;
                  if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
               end
            end
            n_tests++;
            if (max_wait > 2) begin
               n_fail++; $display("FAIL rand_starve[%0d]: got wait %0d grants expected <= 2", c, max_wait);
            end
            for (int i = 0; i < 3; i++) begin
               if (if3.req_ready[i]) pend[i] = 1'b0;
            end
         end

         if (load && pick >= 0) begin
            lane    = if3.req_data[pick*8 +: 8];
            m_valid = 1'b1;
            m_data  = lane;
            m_src   = pick;
            m_ptr   = (pick + 1) % 3;
         end else if (load) begin
            m_valid = 1'b0;
         end
         tick();
      end
      if3.req_valid = '0;
   endtask

   initial begin
      test_reset();
      test_contention();
      test_sparse();
      test_backpressure();
      test_idle_gap();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
